// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : trap_ctrl_pkg
// Brief   : Shared sizes and trap cause codes for the EX trap path.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
package trap_ctrl_pkg;

   localparam int ADDR_W  = 48;
   localparam int INSTR_W = 24;
   localparam int CAUSE_W = 4;

   typedef enum logic [CAUSE_W-1:0] {
      TRAP_NONE      = 4'd0,
      TRAP_ADD_OVF   = 4'd1,
      TRAP_SUB_OVF   = 4'd2,
      TRAP_NEG_OVF   = 4'd3,
      TRAP_SHR_RANGE = 4'd4
   } trap_cause_e;

   // Vector table uses a 16-byte stride per cause.
   function automatic logic [ADDR_W-1:0] trap_vec_offset(input logic [CAUSE_W-1:0] cause);
      return {{(ADDR_W-CAUSE_W-4){1'b0}}, cause, 4'b0000};
   endfunction

endpackage
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : trap_ctrl
// Brief   : Latches EX traps, flushes the pipe, vectors fetch, returns on RTI.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter logic [ADDR_W-1:0] VEC_BASE     = 48'h0000_0100,
   parameter int unsigned       FLUSH_CYCLES = 2
)(
   input  logic                iw_clk,
   input  logic                iw_rst,
   input  logic                iw_trap_req,
   input  logic [CAUSE_W-1:0]  iw_trap_cause,
   input  logic [ADDR_W-1:0]   iw_trap_pc,
   input  logic [INSTR_W-1:0]  iw_trap_instr,
   input  logic                iw_rti,
   input  logic                iw_stall,
   output logic                ow_flush,
   output logic                ow_redirect,
   output logic [ADDR_W-1:0]   ow_redirect_pc,
   output logic [ADDR_W-1:0]   ow_epc,
   output logic [CAUSE_W-1:0]  ow_cause,
   output logic [INSTR_W-1:0]  ow_badinstr,
   output logic                ow_in_trap,
   output logic                ow_halt
);

   localparam logic [2:0] c_st_idle         = 3'd0;
   localparam logic [2:0] c_st_flush        = 3'd1;
   localparam logic [2:0] c_st_redirect     = 3'd2;
   localparam logic [2:0] c_st_handler      = 3'd3;
   localparam logic [2:0] c_st_ret_flush    = 3'd4;
   localparam logic [2:0] c_st_ret_redirect = 3'd5;
   localparam logic [2:0] c_st_halt         = 3'd6;

   localparam logic [2:0] c_flush_init = 3'(FLUSH_CYCLES);

   logic [2:0]         r_state;
   logic [2:0]         r_cnt;
   logic [2:0]         w_state_nxt;
   logic [2:0]         w_cnt_nxt;
   logic               w_accept;
   logic               w_trap_valid;
   logic               w_flush_nxt;
   logic               w_redirect_nxt;
   logic               w_in_trap_nxt;
   logic [ADDR_W-1:0]  w_rpc_nxt;

   logic               r_flush;
   logic               r_redirect;
   logic [ADDR_W-1:0]  r_redirect_pc;
   logic [ADDR_W-1:0]  r_epc;
   logic [CAUSE_W-1:0] r_cause;
   logic [INSTR_W-1:0] r_badinstr;
   logic               r_in_trap;
   logic               r_halt;

   assign w_trap_valid = iw_trap_req && (iw_trap_cause != TRAP_NONE);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      case (r_state)
         c_st_idle: begin
            if (w_trap_valid && !iw_stall) begin
               w_accept    = 1'b1;
               w_cnt_nxt   = c_flush_init;
               w_state_nxt = c_st_flush;
            end
         end
         c_st_flush: begin
            if (!iw_stall) begin
               if (r_cnt <= 3'd1) w_state_nxt = c_st_redirect;
               else               w_cnt_nxt   = r_cnt - 3'd1;
            end
         end
         c_st_redirect: begin
            if (!iw_stall) w_state_nxt = c_st_handler;
         end
         c_st_handler: begin
            // A second trap outranks a simultaneous RTI.
            if (!iw_stall) begin
               if (w_trap_valid) w_state_nxt = c_st_halt;
               else if (iw_rti)  w_state_nxt = c_st_ret_flush;
            end
         end
         c_st_ret_flush: begin
            if (!iw_stall) w_state_nxt = c_st_ret_redirect;
         end
         c_st_ret_redirect: begin
            if (!iw_stall) w_state_nxt = c_st_idle;
         end
         c_st_halt: begin
            w_state_nxt = c_st_halt;
         end
         default: begin
            w_state_nxt = c_st_idle;
         end
      endcase
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_comb begin
      w_flush_nxt    = 1'b0;
      w_redirect_nxt = 1'b0;
      w_in_trap_nxt  = 1'b0;
      w_rpc_nxt      = '0;
      case (w_state_nxt)
         c_st_flush: begin
            w_flush_nxt = 1'b1;
         end
         c_st_redirect: begin
            w_flush_nxt    = 1'b1;
            w_redirect_nxt = 1'b1;
            w_rpc_nxt      = VEC_BASE + trap_vec_offset(r_cause);
         end
         c_st_handler: begin
            w_in_trap_nxt = 1'b1;
         end
         c_st_ret_flush: begin
            w_flush_nxt   = 1'b1;
            w_in_trap_nxt = 1'b1;
         end
         c_st_ret_redirect: begin
            w_redirect_nxt = 1'b1;
            w_rpc_nxt      = r_epc + 48'd1;
         end
         c_st_halt: begin
            w_flush_nxt   = 1'b1;
            w_in_trap_nxt = 1'b1;
         end
         default: begin
            w_flush_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge iw_clk) begin
      if (iw_rst) begin
         r_state       <= c_st_idle;
         r_cnt         <= 3'd0;
         r_flush       <= 1'b0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
         r_epc         <= '0;
         r_cause       <= '0;
         r_badinstr    <= '0;
         r_in_trap     <= 1'b0;
         r_halt        <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_flush       <= w_flush_nxt;
         r_redirect    <= w_redirect_nxt;
         r_redirect_pc <= w_rpc_nxt;
         r_in_trap     <= w_in_trap_nxt;
         r_halt        <= (w_state_nxt == c_st_halt);
         if (w_accept) begin
            r_epc      <= iw_trap_pc;
            r_cause    <= iw_trap_cause;
            r_badinstr <= iw_trap_instr;
         end
      end
   end

   assign ow_flush       = r_flush;
   assign ow_redirect    = r_redirect;
   assign ow_redirect_pc = r_redirect_pc;
   assign ow_epc         = r_epc;
   assign ow_cause       = r_cause;
   assign ow_badinstr    = r_badinstr;
   assign ow_in_trap     = r_in_trap;
   assign ow_halt        = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_trap_ctrl
// Brief   : Directed bench for trap_ctrl with a timeline-based reference model.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_trap_ctrl;

   localparam logic [47:0] VEC     = 48'h0000_0100;
   localparam int          FC      = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        trap_req;
   logic [3:0]  trap_cause;
   logic [47:0] trap_pc;
   logic [23:0] trap_instr;
   logic        rti;
   logic        stall;
   logic        flush, redirect, in_trap, halt;
   logic [47:0] redirect_pc, epc;
   logic [3:0]  cause;
   logic [23:0] badinstr;

   int n_tests = 0;
   int n_fail  = 0;

   trap_ctrl #(.VEC_BASE(VEC), .FLUSH_CYCLES(FC)) dut (
      .iw_clk(clk), .iw_rst(rst), .iw_trap_req(trap_req), .iw_trap_cause(trap_cause),
      .iw_trap_pc(trap_pc), .iw_trap_instr(trap_instr), .iw_rti(rti), .iw_stall(stall),
      .ow_flush(flush), .ow_redirect(redirect), .ow_redirect_pc(redirect_pc),
      .ow_epc(epc), .ow_cause(cause), .ow_badinstr(badinstr),
      .ow_in_trap(in_trap), .ow_halt(halt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a trap or RTI plays out a fixed script of output frames; stalls pause it.
   typedef struct packed {
      logic        flush;
      logic        redirect;
      logic [47:0] rpc;
      logic        in_trap;
      logic        halt;
   } frame_t;

   function automatic frame_t fr(input logic f, input logic r, input logic [47:0] p,
                                 input logic t, input logic h);
      frame_t x;
      x.flush = f; x.redirect = r; x.rpc = p; x.in_trap = t; x.halt = h;
      return x;
   endfunction

   frame_t      cur, dest_f;
   frame_t      script[$];
   int          mode, dest_mode;   // 0 idle, 1 scripted, 2 handler, 3 halted
   logic [47:0] m_epc;
   logic [3:0]  m_cause;
   logic [23:0] m_bad;
   logic        armed = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         cur = '0; mode = 0; script.delete();
         m_epc = '0; m_cause = '0; m_bad = '0;
         armed = 1'b1;
      end else begin
         case (mode)
            0: if (trap_req && !stall && trap_cause != 4'd0) begin
                  m_epc = trap_pc; m_cause = trap_cause; m_bad = trap_instr;
                  script.delete();
                  for (int i = 0; i < FC; i++) script.push_back(fr(1, 0, 48'd0, 0, 0));
                  script.push_back(fr(1, 1, VEC + 48'(trap_cause) * 48'd16, 0, 0));
                  dest_f = fr(0, 0, 48'd0, 1, 0); dest_mode = 2;
                  cur = script.pop_front(); mode = 1;
               end
            1: if (!stall) begin
                  if (script.size() > 0) cur = script.pop_front();
                  else begin cur = dest_f; mode = dest_mode; end
               end
            2: if (!stall) begin
                  if (trap_req && trap_cause != 4'd0) begin
                     cur = fr(1, 0, 48'd0, 1, 1); mode = 3;
                  end else if (rti) begin
                     script.delete();
                     script.push_back(fr(1, 0, 48'd0, 1, 0));
                     script.push_back(fr(0, 1, m_epc + 48'd1, 0, 0));
                     dest_f = '0; dest_mode = 0;
                     cur = script.pop_front(); mode = 1;
                  end
               end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("flush",       {47'd0, flush},    {47'd0, cur.flush});
         chk("redirect",    {47'd0, redirect}, {47'd0, cur.redirect});
         chk("redirect_pc", redirect_pc,       cur.rpc);
         chk("in_trap",     {47'd0, in_trap},  {47'd0, cur.in_trap});
         chk("halt",        {47'd0, halt},     {47'd0, cur.halt});
         chk("epc",         epc,               m_epc);
         chk("cause",       {44'd0, cause},    {44'd0, m_cause});
         chk("badinstr",    {24'd0, badinstr}, {24'd0, m_bad});
      end
   end

   task automatic cyc(input logic req, input logic [3:0] c, input logic [47:0] pc,
                      input logic [23:0] ins, input logic r, input logic s);
      trap_req = req; trap_cause = c; trap_pc = pc; trap_instr = ins; rti = r; stall = s;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 4'd0, 48'd0, 24'd0, 0, 0);
   endtask

   initial begin
      rst = 1'b1;
      idle(2);
      chk("rst_flush", {47'd0, flush}, 48'd0);
      chk("rst_epc", epc, 48'd0);
      rst = 1'b0;
      idle(1);
      cyc(0, 4'd0, 48'd0, 24'd0, 1, 0);                    // RTI in IDLE ignored
      chk("idle_rti", {47'd0, flush | redirect}, 48'd0);

      // Basic trap, cause 1
      cyc(1, 4'd1, 48'h300, 24'h0A1234, 0, 0);
      chk("t1_flush", {47'd0, flush}, 48'd1);
      chk("t1_epc", epc, 48'h300);
      idle(1);
      idle(1);
      chk("t1_redir", {47'd0, redirect}, 48'd1);
      chk("t1_vec", redirect_pc, 48'h110);
      idle(1);
      chk("t1_in_trap", {47'd0, in_trap}, 48'd1);
      chk("t1_bad", {24'd0, badinstr}, 48'h0A1234);
      idle(2);

      // RTI return
      cyc(0, 4'd0, 48'd0, 24'd0, 1, 0);
      chk("r1_flush", {47'd0, flush}, 48'd1);
      idle(1);
      chk("r1_pc", redirect_pc, 48'h301);
      chk("r1_in_trap", {47'd0, in_trap}, 48'd0);
      idle(1);

      // Cause 4 vectors to 0x140
      cyc(1, 4'd4, 48'h500, 24'h123456, 0, 0);
      idle(2);
      chk("t4_vec", redirect_pc, 48'h140);
      idle(2);
      cyc(0, 4'd0, 48'd0, 24'd0, 1, 0);
      idle(3);

      // Stall held through REDIRECT; stalled trap in HANDLER ignored
      cyc(1, 4'd3, 48'h20, 24'h00BEEF, 0, 0);
      idle(2);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 4'd0, 48'd0, 24'd0, 0, 1);
         chk("stall_redir", {47'd0, redirect}, 48'd1);
      end
      idle(1);
      chk("stall_handler", {47'd0, in_trap}, 48'd1);
      cyc(1, 4'd2, 48'h77, 24'h0, 1, 1);
      chk("stall_nohalt", {47'd0, halt | flush}, 48'd0);
      cyc(0, 4'd0, 48'd0, 24'd0, 1, 0);
      idle(3);

      // Stalled or cause-0 requests in IDLE ignored
      cyc(1, 4'd1, 48'h900, 24'h1, 0, 1);
      cyc(1, 4'd0, 48'h900, 24'h1, 0, 0);
      chk("ign_flush", {47'd0, flush}, 48'd0);
      chk("ign_epc", epc, 48'h20);

      // PC wrap on return
      cyc(1, 4'd1, 48'hFFFF_FFFF_FFFF, 24'h2, 0, 0);
      idle(4);
      cyc(0, 4'd0, 48'd0, 24'd0, 1, 0);
      idle(1);
      chk("wrap_pc", redirect_pc, 48'h0);
      chk("wrap_redir", {47'd0, redirect}, 48'd1);
      idle(1);

      // Double fault with simultaneous RTI
      cyc(1, 4'd1, 48'h300, 24'h0A1234, 0, 0);
      idle(4);
      cyc(1, 4'd2, 48'h400, 24'h3, 1, 0);
      chk("df_halt", {47'd0, halt}, 48'd1);
      chk("df_cause", {44'd0, cause}, 48'd1);
      idle(2);
      cyc(1, 4'd3, 48'h500, 24'h4, 1, 0);
      chk("df_sticky", {47'd0, halt}, 48'd1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("df_rst_halt", {47'd0, halt}, 48'd0);

      // Reset during FLUSH, then a fresh trap
      cyc(1, 4'd1, 48'h40, 24'h5, 0, 0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("rf_flush", {47'd0, flush}, 48'd0);
      chk("rf_epc", epc, 48'd0);
      cyc(1, 4'd2, 48'h80, 24'h6, 0, 0);
      idle(2);
      chk("rf_vec", redirect_pc, 48'h120);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
